// File: rtl/cr_lsu_randclk_gen.sv
// cr_lsu_randclk_gen: pseudo-random clock-enable generator for LSU datapath buffers.
// Each channel raises mod_en for a fixed burst when its LFSR nibble falls below
// the density threshold, then rests for a guard period. mod_en is only ever ORed
// into a clock-gate enable, so it can add clock pulses but never remove one.
// Optional feature macro: CR_LSU_RANDCLK_SEED_EN adds the seed-load handshake ports.
module cr_lsu_randclk_gen #(
    parameter int unsigned          CH_NUM    = 4,
    parameter int unsigned          LFSR_W    = 16,
    parameter logic [LFSR_W-1:0]    TAP_MASK  = LFSR_W'(16'hB400),
    parameter logic [LFSR_W-1:0]    SEED      = LFSR_W'(16'hACE1),
    parameter int unsigned          BURST_LEN = 4,
    parameter int unsigned          GUARD_LEN = 1
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst,
    input  logic                randclk_glb_en,
    input  logic [CH_NUM-1:0]   randclk_ch_en,
    input  logic [3:0]          randclk_density,
`ifdef CR_LSU_RANDCLK_SEED_EN
    input  logic                randclk_seed_vld,
    input  logic [LFSR_W-1:0]   randclk_seed_data,
    output logic                randclk_seed_rdy,
`endif
    output logic [CH_NUM-1:0]   randclk_mod_en,
    output logic [LFSR_W-1:0]   randclk_lfsr_val
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [LFSR_W-1:0] lfsr_shift;
    logic [LFSR_W-1:0] lfsr_step;
    logic              seed_load;
    logic [LFSR_W-1:0] seed_val;

    state_e            state_q [CH_NUM];
    state_e            state_d [CH_NUM];
    logic [CNT_W-1:0]  cnt_q   [CH_NUM];
    logic [CNT_W-1:0]  cnt_d   [CH_NUM];
    logic [CH_NUM-1:0] mod_en_q, mod_en_d;

    // Seed handshake: loads only while the generator is globally idle; zero maps to SEED.
`ifdef CR_LSU_RANDCLK_SEED_EN
    assign randclk_seed_rdy = ~randclk_glb_en;
    assign seed_load        = randclk_seed_vld & randclk_seed_rdy;
    assign seed_val         = (randclk_seed_data == '0) ? SEED : randclk_seed_data;
`else
    assign seed_load        = 1'b0;
    assign seed_val         = SEED;
`endif

    // Galois LFSR step and next-value select (seed load wins over stepping).
    always_comb begin
        lfsr_shift = lfsr_q >> 1;
        lfsr_step  = lfsr_q[0] ? (lfsr_shift ^ TAP_MASK) : lfsr_shift;
        lfsr_d     = lfsr_q;
        if (seed_load) begin
            lfsr_d = seed_val;
        end else if (randclk_glb_en) begin
            lfsr_d = lfsr_step;
        end
    end

    // Per-channel burst/guard sequencer; any disable collapses the channel to IDLE.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            mod_en_d[i] = 1'b0;
            if (!(randclk_glb_en && randclk_ch_en[i])) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (lfsr_q[NIB_W*i +: NIB_W] < randclk_density) begin
                            state_d[i] = ST_BURST;
                            cnt_d[i]   = CNT_W'(BURST_LEN - 1);
                        end
                    end
                    ST_BURST: begin
                        if (cnt_q[i] == '0) begin
                            if (GUARD_LEN == 0) begin
                                state_d[i] = ST_IDLE;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = ST_GUARD;
                                cnt_d[i]   = CNT_W'(GUARD_LEN - 1);
                            end
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    ST_GUARD: begin
                        if (cnt_q[i] == '0) begin
                            state_d[i] = ST_IDLE;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            mod_en_d[i] = (state_d[i] == ST_BURST);
        end
    end

    // State, counter, LFSR and output registers.
    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            lfsr_q   <= SEED;
            mod_en_q <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            lfsr_q   <= lfsr_d;
            mod_en_q <= mod_en_d;
            for (int i = 0; i < CH_NUM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign randclk_mod_en   = mod_en_q;
    assign randclk_lfsr_val = lfsr_q;

endmodule

// File: tb/tb_cr_lsu_randclk_gen.sv
// tb_cr_lsu_randclk_gen: self-checking bench for cr_lsu_randclk_gen.
// Reference model tracks, per channel, the edge of the last hit and derives
// the mod_en window and the next eligible edge from burst/guard lengths.
module tb_cr_lsu_randclk_gen;

    localparam int CH = 4;
    localparam int LW = 16;
    localparam int BL = 4;
    localparam int GL = 1;
    localparam logic [15:0] TAP   = 16'hB400;
    localparam logic [15:0] SEEDV = 16'hACE1;

    logic          clk;
    logic          cpurst;
    logic          glb_en;
    logic [CH-1:0] ch_en;
    logic [3:0]    density;
    logic          seed_vld;
    logic [LW-1:0] seed_data;
    logic          seed_rdy;
    logic [CH-1:0] mod_en;
    logic [LW-1:0] lfsr_val;

    int n_checks;
    int n_fail;

    int            m_edge;
    int            m_hit [CH];
    logic [15:0]   m_lfsr;
    logic [CH-1:0] m_mod;

    cr_lsu_randclk_gen #(
        .CH_NUM    (CH),
        .LFSR_W    (LW),
        .TAP_MASK  (TAP),
        .SEED      (SEEDV),
        .BURST_LEN (BL),
        .GUARD_LEN (GL)
    ) dut (
        .forever_cpuclk    (clk),
        .cpurst            (cpurst),
        .randclk_glb_en    (glb_en),
        .randclk_ch_en     (ch_en),
        .randclk_density   (density),
`ifdef CR_LSU_RANDCLK_SEED_EN
        .randclk_seed_vld  (seed_vld),
        .randclk_seed_data (seed_data),
        .randclk_seed_rdy  (seed_rdy),
`endif
        .randclk_mod_en    (mod_en),
        .randclk_lfsr_val  (lfsr_val)
    );

`ifndef CR_LSU_RANDCLK_SEED_EN
    assign seed_rdy = ~glb_en;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] gal(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ TAP) : (v >> 1);
    endfunction

    task automatic model_reset();
        m_lfsr = SEEDV;
        m_mod  = '0;
        m_edge = 0;
        for (int i = 0; i < CH; i++) m_hit[i] = -100;
    endtask

    // Apply one clock edge of the reference model using the current inputs.
    task automatic model_edge();
        bit en;
        for (int i = 0; i < CH; i++) begin
            en = glb_en && ch_en[i];
            if (!en) begin
                m_hit[i] = -100;
            end else if ((m_edge >= m_hit[i] + BL + GL + 1) && (m_lfsr[4*i +: 4] < density)) begin
                m_hit[i] = m_edge;
            end
            m_mod[i] = en && (m_edge >= m_hit[i]) && (m_edge <= m_hit[i] + BL - 1);
        end
`ifdef CR_LSU_RANDCLK_SEED_EN
        if (seed_vld && !glb_en) m_lfsr = (seed_data == 16'h0) ? SEEDV : seed_data;
        else if (glb_en)         m_lfsr = gal(m_lfsr);
`else
        if (glb_en) m_lfsr = gal(m_lfsr);
`endif
        m_edge++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        n_checks++;
        if (mod_en !== m_mod) begin
            n_fail++;
            $display("FAIL mod_en edge %0d: got %b exp %b", m_edge, mod_en, m_mod);
        end
        n_checks++;
        if (lfsr_val !== m_lfsr) begin
            n_fail++;
            $display("FAIL lfsr_val edge %0d: got %h exp %h", m_edge, lfsr_val, m_lfsr);
        end
    endtask

    task automatic do_reset();
        cpurst = 1'b1;
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        glb_en = 1'b0; ch_en = '0; density = '0; seed_vld = 1'b0; seed_data = '0;
        cpurst = 1'b1;
        #3;
        @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (mod_en !== 4'h0) begin n_fail++; $display("FAIL reset_mod_en: got %b exp 0000", mod_en); end
        n_checks++;
        if (lfsr_val !== 16'hACE1) begin n_fail++; $display("FAIL reset_lfsr: got %h exp ace1", lfsr_val); end
        n_checks++;
        if (seed_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_seed_rdy: got %b exp 1", seed_rdy); end
        cpurst = 1'b0;
        repeat (20) step();
        n_checks++;
        if (lfsr_val !== 16'hACE1) begin n_fail++; $display("FAIL idle_hold_lfsr: got %h exp ace1", lfsr_val); end
    endtask

    task automatic test_density_zero();
        logic [CH-1:0] any_high;
        any_high = '0;
        glb_en = 1'b1; ch_en = 4'hF; density = 4'd0;
        step();
        n_checks++;
        if (lfsr_val !== 16'hE270) begin n_fail++; $display("FAIL first_step: got %h exp e270", lfsr_val); end
        for (int k = 0; k < 999; k++) begin
            step();
            any_high |= mod_en;
        end
        n_checks++;
        if (any_high !== 4'h0) begin n_fail++; $display("FAIL density0_never_high: got %b exp 0000", any_high); end
    endtask

    task automatic test_density_full();
        int run [CH];
        int gap [CH];
        int runs [CH];
        do_reset();
        glb_en = 1'b1; ch_en = 4'hF; density = 4'd15;
        for (int i = 0; i < CH; i++) begin run[i] = 0; gap[i] = 0; runs[i] = 0; end
        for (int k = 0; k < 300; k++) begin
            step();
            for (int i = 0; i < CH; i++) begin
                if (mod_en[i]) begin
                    if (run[i] == 0 && runs[i] > 0) begin
                        n_checks++;
                        if (gap[i] < GL) begin n_fail++; $display("FAIL gap_len ch%0d: got %0d exp >=%0d", i, gap[i], GL); end
                    end
                    run[i]++;
                    gap[i] = 0;
                end else begin
                    if (run[i] != 0) begin
                        n_checks++;
                        if (run[i] != BL) begin n_fail++; $display("FAIL burst_len ch%0d: got %0d exp %0d", i, run[i], BL); end
                        runs[i]++;
                    end
                    run[i] = 0;
                    gap[i]++;
                end
            end
        end
        for (int i = 0; i < CH; i++) begin
            n_checks++;
            if (runs[i] < 10) begin n_fail++; $display("FAIL burst_count ch%0d: got %0d exp >=10", i, runs[i]); end
        end
    endtask

    task automatic test_disable_mid_burst();
        int run2;
        bit found;
        logic [15:0] saved;
        run2 = 0; found = 1'b0;
        do_reset();
        glb_en = 1'b1; ch_en = 4'hF; density = 4'd15;
        for (int k = 0; k < 60 && !found; k++) begin
            step();
            run2 = mod_en[2] ? run2 + 1 : 0;
            if (run2 == 2) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL mid_burst_timeout: got none exp ch2 burst"); end
        ch_en[2] = 1'b0;
        step();
        n_checks++;
        if (mod_en[2] !== 1'b0) begin n_fail++; $display("FAIL ch_disable: got %b exp 0", mod_en[2]); end
        repeat (3) step();
        saved = m_lfsr;
        glb_en = 1'b0;
        step();
        n_checks++;
        if (mod_en !== 4'h0) begin n_fail++; $display("FAIL glb_disable: got %b exp 0000", mod_en); end
        step();
        n_checks++;
        if (lfsr_val !== saved) begin n_fail++; $display("FAIL lfsr_freeze: got %h exp %h", lfsr_val, saved); end
        ch_en = 4'hF;
    endtask

    task automatic test_seed();
`ifdef CR_LSU_RANDCLK_SEED_EN
        glb_en = 1'b0; seed_vld = 1'b1; seed_data = 16'h1234;
        step();
        n_checks++;
        if (lfsr_val !== 16'h1234) begin n_fail++; $display("FAIL seed_load: got %h exp 1234", lfsr_val); end
        seed_data = 16'h0000;
        step();
        n_checks++;
        if (lfsr_val !== 16'hACE1) begin n_fail++; $display("FAIL seed_zero: got %h exp ace1", lfsr_val); end
        glb_en = 1'b1; seed_data = 16'h5555;
        #1;
        n_checks++;
        if (seed_rdy !== 1'b0) begin n_fail++; $display("FAIL seed_rdy_busy: got %b exp 0", seed_rdy); end
        step();
        n_checks++;
        if (lfsr_val !== 16'hE270) begin n_fail++; $display("FAIL seed_ignored: got %h exp e270", lfsr_val); end
        seed_vld = 1'b0;
        glb_en = 1'b0;
        step();
`endif
    endtask

    task automatic test_async_reset();
        bit found;
        found = 1'b0;
        do_reset();
        glb_en = 1'b1; ch_en = 4'hF; density = 4'd15;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (mod_en != 4'h0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL async_burst_timeout: got none exp burst"); end
        #2;
        cpurst = 1'b1;
        #1;
        n_checks++;
        if (mod_en !== 4'h0) begin n_fail++; $display("FAIL async_reset_mod: got %b exp 0000", mod_en); end
        n_checks++;
        if (lfsr_val !== 16'hACE1) begin n_fail++; $display("FAIL async_reset_lfsr: got %h exp ace1", lfsr_val); end
        @(posedge clk);
        #1;
        cpurst = 1'b0;
        model_reset();
        repeat (10) step();
    endtask

    task automatic test_random();
        do_reset();
        glb_en = 1'b1; ch_en = 4'hF; density = 4'd8; seed_vld = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(19, 0) == 0) glb_en = ~glb_en;
            if ($urandom_range(9, 0) == 0)  ch_en = 4'($urandom);
            if ($urandom_range(14, 0) == 0) density = 4'($urandom);
            seed_vld  = ($urandom_range(3, 0) == 0);
            seed_data = ($urandom_range(7, 0) == 0) ? 16'h0 : 16'($urandom);
            step();
        end
        seed_vld = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cpurst   = 1'b1;
        model_reset();
        test_reset();
        test_density_zero();
        test_density_full();
        test_disable_mid_burst();
        test_seed();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
